// File: rtl/cpu_regfile_io.sv
// cpu_regfile_io: register file with registered read ports, buffered OUT FIFO and sticky interrupt latch.
// Optional macro REGFILE_BYPASS_EN enables read-after-write forwarding on both read ports.
module cpu_regfile_io #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TMR_N     = 2
) (
  input  logic                         CPU_clock,
  input  logic                         CPU_reset,
  input  logic [ADDR_W-1:0]            RD0_SEL,
  input  logic [ADDR_W-1:0]            RD1_SEL,
  output logic [DATA_W-1:0]            RD0_DATA,
  output logic [DATA_W-1:0]            RD1_DATA,
  input  logic                         WR_ALU,
  input  logic                         WR_LOAD,
  input  logic [ADDR_W-1:0]            WR_SEL,
  input  logic [DATA_W-1:0]            ALU_DIN,
  input  logic [DATA_W-1:0]            LOAD_DIN,
  input  logic [DATA_W-1:0]            OUT_DEV_IN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [DATA_W-1:0]            OUT_DEVICE,
  output logic [DATA_W-1:0]            OUT_DATA,
  output logic [$clog2(OUT_DEPTH):0]   OUT_COUNT,
  output logic                         OUT_OVERFLOW,
  input  logic                         ITR,
  input  logic [TMR_N-1:0]             TMR_FLAGS,
  input  logic                         ITR_ACK,
  output logic                         ITR_PENDING,
  output logic [TMR_N:0]               ITR_SRC
);
  localparam int REG_N = 2**ADDR_W;
  localparam int PW    = $clog2(OUT_DEPTH);
  localparam int CW    = PW + 1;

  logic [DATA_W-1:0] r_regs [REG_N];
  logic [DATA_W-1:0] r_dev  [OUT_DEPTH];
  logic [DATA_W-1:0] r_dat  [OUT_DEPTH];
  logic [DATA_W-1:0] r_rd0, r_rd1;
  logic [PW-1:0]     r_rp, r_wp;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic [TMR_N:0]    r_src;

  logic              w_wr, w_out_cmd, w_full, w_pop, w_push, w_drop;
  logic [DATA_W-1:0] w_wdata, w_rd0, w_rd1;

  always_comb begin
    w_wr      = WR_ALU ^ WR_LOAD;
    w_out_cmd = WR_ALU & WR_LOAD;
    w_wdata   = WR_ALU ? ALU_DIN : LOAD_DIN;
    w_full    = r_cnt == CW'(OUT_DEPTH);
    w_pop     = OUT_VALID & OUT_READY;
    w_push    = w_out_cmd & (~w_full | w_pop);
    w_drop    = w_out_cmd & w_full & ~w_pop;
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    w_rd0 = (w_wr && WR_SEL == RD0_SEL) ? w_wdata : r_regs[RD0_SEL];
    w_rd1 = (w_wr && WR_SEL == RD1_SEL) ? w_wdata : r_regs[RD1_SEL];
  end
`else
  always_comb begin
    w_rd0 = r_regs[RD0_SEL];
    w_rd1 = r_regs[RD1_SEL];
  end
`endif

  always_ff @(posedge CPU_clock) begin
    if (CPU_reset) begin
      for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
      r_rd0 <= '0;
      r_rd1 <= '0;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_src <= '0;
    end else begin
      if (w_wr) r_regs[WR_SEL] <= w_wdata;
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_drop) r_ovf <= 1'b1;
      r_src <= (ITR_ACK ? '0 : r_src) | {TMR_FLAGS, ITR};
    end
  end

  // FIFO storage needs no reset: outputs are masked while empty
  always_ff @(posedge CPU_clock) begin
    if (!CPU_reset && w_push) begin
      r_dev[r_wp] <= OUT_DEV_IN;
      r_dat[r_wp] <= ALU_DIN;
    end
  end

  always_comb begin
    RD0_DATA     = r_rd0;
    RD1_DATA     = r_rd1;
    OUT_VALID    = r_cnt != '0;
    OUT_DEVICE   = OUT_VALID ? r_dev[r_rp] : '0;
    OUT_DATA     = OUT_VALID ? r_dat[r_rp] : '0;
    OUT_COUNT    = r_cnt;
    OUT_OVERFLOW = r_ovf;
    ITR_SRC      = r_src;
    ITR_PENDING  = |r_src;
  end
endmodule

// File: tb/tb_cpu_regfile_io.sv
// tb_cpu_regfile_io: scoreboard bench for cpu_regfile_io (reads, writes, OUT FIFO, interrupts).
module tb_cpu_regfile_io;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd0_sel, rd1_sel, wr_sel;
  logic [15:0] rd0_data, rd1_data, alu_din, load_din, out_dev_in, out_device, out_data;
  logic        wr_alu, wr_load, out_valid, out_ready, out_overflow, itr, itr_ack, itr_pending;
  logic [2:0]  out_count, itr_src;
  logic [1:0]  tmr_flags;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] model [16];
  logic [15:0] rd_q [$];
  logic [31:0] out_q [$];

  cpu_regfile_io dut (
    .CPU_clock(clk), .CPU_reset(rst), .RD0_SEL(rd0_sel), .RD1_SEL(rd1_sel),
    .RD0_DATA(rd0_data), .RD1_DATA(rd1_data), .WR_ALU(wr_alu), .WR_LOAD(wr_load),
    .WR_SEL(wr_sel), .ALU_DIN(alu_din), .LOAD_DIN(load_din), .OUT_DEV_IN(out_dev_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DEVICE(out_device), .OUT_DATA(out_data),
    .OUT_COUNT(out_count), .OUT_OVERFLOW(out_overflow), .ITR(itr), .TMR_FLAGS(tmr_flags),
    .ITR_ACK(itr_ack), .ITR_PENDING(itr_pending), .ITR_SRC(itr_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_alu = 0; wr_load = 0; itr = 0; itr_ack = 0; tmr_flags = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < 16; i++) begin
      wr_alu = 1; wr_sel = 4'(i); alu_din = 16'h1000 + 16'(i);
      tick();
    end
    wr_alu = 1; wr_load = 1; out_dev_in = 16'h7; alu_din = 16'h55; itr = 1;
    tick();
    out_ready = 1;
    do_reset();
    out_ready = 0;
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_fifo valid=%b count=%0d expected 0/0", out_valid, out_count);
    end
    n_checks++;
    if (itr_pending !== 1'b0 || itr_src !== 3'b000 || out_overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags pend=%b src=%b ovf=%b expected 0", itr_pending, itr_src, out_overflow);
    end
    n_checks++;
    if (out_device !== 16'h0 || out_data !== 16'h0 || rd0_data !== 16'h0 || rd1_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs dev=%h data=%h rd0=%h rd1=%h expected 0", out_device, out_data, rd0_data, rd1_data);
    end
    for (int i = 0; i < 16; i++) begin
      rd0_sel = 4'(i); rd1_sel = 4'(15 - i);
      rd_q.push_back(model[i]); rd_q.push_back(model[15 - i]);
      tick();
      begin
        logic [15:0] e0, e1;
        e0 = rd_q.pop_front(); e1 = rd_q.pop_front();
        n_checks++;
        if (rd0_data !== e0 || rd1_data !== e1) begin
          n_fail++; $display("FAIL reset_read idx=%0d rd0=%h rd1=%h expected %h/%h", i, rd0_data, rd1_data, e0, e1);
        end
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_alu = 1; wr_sel = 3; alu_din = 16'h1234; model[3] = 16'h1234;
    tick();
    wr_alu = 0; wr_load = 1; wr_sel = 5; load_din = 16'hBEEF; alu_din = 16'hDEAD; model[5] = 16'hBEEF;
    tick();
    idle();
    rd0_sel = 3; rd1_sel = 5;
    rd_q.push_back(model[3]); rd_q.push_back(model[5]);
    tick();
    begin
      logic [15:0] e0, e1;
      e0 = rd_q.pop_front(); e1 = rd_q.pop_front();
      n_checks++;
      if (rd0_data !== e0 || rd1_data !== e1) begin
        n_fail++; $display("FAIL write_read rd0=%h rd1=%h expected %h/%h", rd0_data, rd1_data, e0, e1);
      end
    end
  endtask

  task automatic test_same_edge();
    logic [15:0] e;
    idle();
    wr_alu = 1; wr_sel = 7; alu_din = 16'h0001; model[7] = 16'h0001;
    tick();
    wr_alu = 1; wr_sel = 7; alu_din = 16'hA5A5; rd0_sel = 7; rd1_sel = 3;
`ifdef REGFILE_BYPASS_EN
    rd_q.push_back(16'hA5A5);
`else
    rd_q.push_back(model[7]);
`endif
    model[7] = 16'hA5A5;
    tick();
    idle();
    e = rd_q.pop_front();
    n_checks++;
    if (rd0_data !== e || rd1_data !== model[3]) begin
      n_fail++; $display("FAIL same_edge rd0=%h rd1=%h expected %h/%h", rd0_data, rd1_data, e, model[3]);
    end
    tick();
    n_checks++;
    if (rd0_data !== 16'hA5A5) begin
      n_fail++; $display("FAIL same_edge_after rd0=%h expected a5a5", rd0_data);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    out_ready = 1;
    guard = 0;
    while (out_q.size() != 0 && guard < 20) begin
      logic [31:0] e;
      if (out_valid) begin
        e = out_q.pop_front();
        n_checks++;
        if ({out_device, out_data} !== e) begin
          n_fail++; $display("FAIL %s_head dev/data=%h expected %h", name, {out_device, out_data}, e);
        end
      end
      tick();
      guard++;
    end
    n_checks++;
    if (out_q.size() != 0 || out_valid !== 1'b0 || out_count !== 3'd0) begin
      n_fail++; $display("FAIL %s_drain left=%0d valid=%b count=%0d expected 0/0/0", name, out_q.size(), out_valid, out_count);
    end
    out_q.delete();
  endtask

  task automatic test_fifo_overflow();
    int cnt;
    idle();
    out_ready = 0; cnt = 0;
    for (int k = 0; k < 5; k++) begin
      wr_alu = 1; wr_load = 1; wr_sel = 3; out_dev_in = 16'h0002; alu_din = 16'h0010 + 16'(k);
      if (cnt < 4) begin out_q.push_back({16'h0002, alu_din}); cnt++; end
      tick();
      if (k == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0010) begin
          n_fail++; $display("FAIL fifo_first valid=%b data=%h expected 1/0010", out_valid, out_data);
        end
      end
    end
    idle();
    n_checks++;
    if (out_count !== 3'(cnt) || out_overflow !== 1'b1) begin
      n_fail++; $display("FAIL fifo_full count=%0d ovf=%b expected %0d/1", out_count, out_overflow, cnt);
    end
    rd0_sel = 3; rd1_sel = 5;
    tick();
    n_checks++;
    if (rd0_data !== model[3] || rd1_data !== model[5]) begin
      n_fail++; $display("FAIL out_no_write rd0=%h rd1=%h expected %h/%h", rd0_data, rd1_data, model[3], model[5]);
    end
    drain("overflow");
    n_checks++;
    if (out_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky ovf=%b expected 1", out_overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      wr_alu = 1; wr_load = 1; out_dev_in = 16'h0003; alu_din = 16'h0020 + 16'(k);
      out_q.push_back({out_dev_in, alu_din});
      tick();
    end
    out_ready = 1; out_dev_in = 16'h0004; alu_din = 16'h0099;
    begin
      logic [31:0] e;
      e = out_q.pop_front();
      n_checks++;
      if ({out_device, out_data} !== e) begin
        n_fail++; $display("FAIL b2b_head dev/data=%h expected %h", {out_device, out_data}, e);
      end
    end
    out_q.push_back({16'h0004, 16'h0099});
    tick();
    idle();
    n_checks++;
    if (out_count !== 3'd4 || out_overflow !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full count=%0d ovf=%b expected 4/0", out_count, out_overflow);
    end
    drain("b2b");
    tick(); tick();
    n_checks++;
    if (out_count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      n_fail++; $display("FAIL empty_ready count=%0d valid=%b data=%h expected 0/0/0", out_count, out_valid, out_data);
    end
    out_ready = 0;
  endtask

  task automatic test_irq();
    logic [2:0] m;
    logic [2:0] exp_src [$];
    logic [3:0] stim [4];
    stim[0] = 4'b0100; stim[1] = 4'b0000; stim[2] = 4'b1001; stim[3] = 4'b1000;
    idle();
    m = 3'b000;
    for (int s = 0; s < 4; s++) begin
      itr_ack = stim[s][3]; tmr_flags = stim[s][2:1]; itr = stim[s][0];
      m = (itr_ack ? 3'b000 : m) | {tmr_flags, itr};
      exp_src.push_back(m);
      tick();
      begin
        logic [2:0] e;
        e = exp_src.pop_front();
        n_checks++;
        if (itr_src !== e || itr_pending !== (|e)) begin
          n_fail++; $display("FAIL irq_step%0d src=%b pend=%b expected %b/%b", s, itr_src, itr_pending, e, |e);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1; rd0_sel = 0; rd1_sel = 0; wr_sel = 0; alu_din = 0; load_din = 0;
    out_dev_in = 0; out_ready = 0;
    idle();
    tick();
    rst = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    test_reset();
    test_write_read();
    test_same_edge();
    test_fifo_overflow();
    test_back_to_back();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
